// File: rtl/sdc_single_blk_wr_mod_pkg.sv
// Shared definitions for the SD-card single-block write path: FSM encoding,
// CRC16 polynomial and the card's CRC-status tokens.
package sdc_single_blk_wr_mod_pkg;

    typedef enum logic [9:0] {
        ST_IDLE      = 10'b00_0000_0001,
        ST_FETCH     = 10'b00_0000_0010,
        ST_START     = 10'b00_0000_0100,
        ST_SEND_DAT  = 10'b00_0000_1000,
        ST_SEND_CRC  = 10'b00_0001_0000,
        ST_END_BIT   = 10'b00_0010_0000,
        ST_RELEASE   = 10'b00_0100_0000,
        ST_RD_STAT   = 10'b00_1000_0000,
        ST_WAIT_BUSY = 10'b01_0000_0000,
        ST_DONE      = 10'b10_0000_0000
    } state_t;

    localparam logic [15:0] CRC16_POLY  = 16'h1021;

    localparam logic [2:0]  TOK_ACCEPT  = 3'b010;
    localparam logic [2:0]  TOK_CRC_BAD = 3'b101;
    localparam logic [2:0]  TOK_WR_ERR  = 3'b110;

    // One serial step of the x^16+x^12+x^5+1 LFSR.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
        return {crc[14:0], 1'b0} ^ (((crc[15] ^ b) == 1'b1) ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/sdc_single_blk_wr_mod_crc16.sv
// Serial CRC16 generator for SD data lines; shared by the read and write paths.
module sdc_crc16_gen
    import sdc_single_blk_wr_mod_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] crc
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr) begin
            crc_d = '0;
        end else if (en) begin
            crc_d = crc16_step(crc_q, bit_in);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/sdc_single_blk_wr_mod.sv
// Single-block write on the SD D0 line: start bit, data, CRC16, end bit,
// then CRC-status token and busy handling from the card.
module sdc_single_blk_wr_mod
    import sdc_single_blk_wr_mod_pkg::*;
#(
    parameter int WRD_NUM  = 64,
    parameter int STAT_TMO = 16
) (
    input  logic        sdc_clk,
    input  logic        reset,
    input  logic        strt_wr_strb,
    input  logic [63:0] dat_wrd,
    input  logic        d0_in,
    output logic        d0_out,
    output logic        d0_oe,
    output logic        rd_wrd_strb,
    output logic        tfc,
    output logic        crc_err,
    output logic        wr_busy
);

    localparam logic [7:0] WRD_LAST = 8'(WRD_NUM - 1);
    localparam logic [5:0] TMO_LAST = 6'(STAT_TMO - 1);

    state_t      state_q,    state_d;
    logic [5:0]  bit_cnt_q,  bit_cnt_d;
    logic [7:0]  wrd_cnt_q,  wrd_cnt_d;
    logic [2:0]  stat_cnt_q, stat_cnt_d;
    logic [2:0]  tok_q,      tok_d;
    logic [63:0] shift_q,    shift_d;
    logic        crc_err_q,  crc_err_d;

    logic        crc_clr;
    logic        crc_en;
    logic [15:0] crc_val;
    logic [3:0]  crc_idx;

    assign crc_clr = (state_q == ST_IDLE) && strt_wr_strb;
    assign crc_en  = (state_q == ST_SEND_DAT);
    assign crc_idx = 4'd15 - bit_cnt_q[3:0];

    sdc_crc16_gen u_crc (
        .clk    (sdc_clk),
        .reset  (reset),
        .clr    (crc_clr),
        .en     (crc_en),
        .bit_in (shift_q[63]),
        .crc    (crc_val)
    );

    always_ff @(posedge sdc_clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            wrd_cnt_q  <= '0;
            stat_cnt_q <= '0;
            tok_q      <= '0;
            shift_q    <= '0;
            crc_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            wrd_cnt_q  <= wrd_cnt_d;
            stat_cnt_q <= stat_cnt_d;
            tok_q      <= tok_d;
            shift_q    <= shift_d;
            crc_err_q  <= crc_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        wrd_cnt_d  = wrd_cnt_q;
        stat_cnt_d = stat_cnt_q;
        tok_d      = tok_q;
        shift_d    = shift_q;
        crc_err_d  = crc_err_q;
        case (state_q)
            ST_IDLE: begin
                if (strt_wr_strb) begin
                    state_d   = ST_FETCH;
                    crc_err_d = 1'b0;
                    bit_cnt_d = '0;
                    wrd_cnt_d = '0;
                end
            end
            ST_FETCH: state_d = ST_START;
            ST_START: begin
                shift_d   = dat_wrd;
                bit_cnt_d = '0;
                wrd_cnt_d = '0;
                state_d   = ST_SEND_DAT;
            end
            ST_SEND_DAT: begin
                bit_cnt_d = bit_cnt_q + 6'd1;
                // The next word arrives while bit 0 is on the line, so reload without a gap.
                if (bit_cnt_q == 6'd63) begin
                    if (wrd_cnt_q == WRD_LAST) begin
                        wrd_cnt_d = '0;
                        state_d   = ST_SEND_CRC;
                    end else begin
                        wrd_cnt_d = wrd_cnt_q + 8'd1;
                        shift_d   = dat_wrd;
                    end
                end else begin
                    shift_d = {shift_q[62:0], 1'b0};
                end
            end
            ST_SEND_CRC: begin
                if (bit_cnt_q == 6'd15) begin
                    bit_cnt_d = '0;
                    state_d   = ST_END_BIT;
                end else begin
                    bit_cnt_d = bit_cnt_q + 6'd1;
                end
            end
            ST_END_BIT: begin
                bit_cnt_d = '0;
                state_d   = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (bit_cnt_q == 6'd1) begin
                    bit_cnt_d  = '0;
                    stat_cnt_d = '0;
                    state_d    = ST_RD_STAT;
                end else begin
                    bit_cnt_d = bit_cnt_q + 6'd1;
                end
            end
            ST_RD_STAT: begin
                // stat_cnt: 0 = hunting start bit, 1..3 = token bits, 4 = end bit.
                if (stat_cnt_q == 3'd0) begin
                    if (!d0_in) begin
                        stat_cnt_d = 3'd1;
                        bit_cnt_d  = '0;
                    end else if (bit_cnt_q == TMO_LAST) begin
                        crc_err_d = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = ST_DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                end else if (stat_cnt_q <= 3'd3) begin
                    tok_d      = {tok_q[1:0], d0_in};
                    stat_cnt_d = stat_cnt_q + 3'd1;
                end else begin
                    case (tok_q)
                        TOK_ACCEPT:              crc_err_d = crc_err_q;
                        TOK_CRC_BAD, TOK_WR_ERR: crc_err_d = 1'b1;
                        default:                 crc_err_d = 1'b1;
                    endcase
                    stat_cnt_d = '0;
                    state_d    = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                if (d0_in) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        d0_oe       = 1'b0;
        d0_out      = 1'b1;
        rd_wrd_strb = 1'b0;
        tfc         = 1'b0;
        case (state_q)
            ST_FETCH: rd_wrd_strb = 1'b1;
            ST_START: begin
                d0_oe  = 1'b1;
                d0_out = 1'b0;
            end
            ST_SEND_DAT: begin
                d0_oe       = 1'b1;
                d0_out      = shift_q[63];
                rd_wrd_strb = (bit_cnt_q == 6'd62) && (wrd_cnt_q != WRD_LAST);
            end
            ST_SEND_CRC: begin
                d0_oe  = 1'b1;
                d0_out = crc_val[crc_idx];
            end
            ST_END_BIT: d0_oe = 1'b1;
            ST_DONE:    tfc   = 1'b1;
            default: ;
        endcase
    end

    assign crc_err = crc_err_q;
    assign wr_busy = (state_q != ST_IDLE);

endmodule
